// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: serves one 64-byte line (eight 64-bit beats) per request
// from an internal word array, with a bench-side preload write port.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int RESP_LATENCY   = 4,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    input  logic                      preload_we,
    input  logic [AW-1:0]             preload_addr,
    input  logic [BUS_DATA_WIDTH-1:0] preload_data
);

    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
    // Counter is preloaded one short so the first beat appears RESP_LATENCY cycles
    // after the cycle following the accept.
    localparam logic [3:0] LAT_INIT = 4'((RESP_LATENCY > 0) ? RESP_LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WDATA, LATENCY, RESP} state_t;

    state_t                    state_q, state_d;
    logic [AW-4:0]             line_q;
    logic [2:0]                cnt_q;
    logic [3:0]                lat_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic [BUS_DATA_WIDTH-1:0] resp_q;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [AW-4:0]             req_line;
    logic                      is_mem, is_rd, resp_hs, wr_en;
    logic [AW-4:0]             rd_line;
    logic [2:0]                rd_beat;
    logic [BUS_DATA_WIDTH-1:0] rd_word;

    // Line-aligned word index: address bits above the array size are dropped.
    assign req_line = bus_req[AW+2:6];
    assign is_mem   = (bus_reqtag[11:8] == SYSBUS_MEMORY);
    assign is_rd    = bus_reqtag[12];
    assign resp_hs  = bus_respcyc & bus_respack;
    assign wr_en    = (state_q == WDATA) & bus_reqack;

    assign bus_resp    = resp_q;
    assign bus_resptag = tag_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus_reqack && is_mem) begin
                    if (!is_rd)                 state_d = WDATA;
                    else if (RESP_LATENCY == 0) state_d = RESP;
                    else                        state_d = LATENCY;
                end
            end
            WDATA:   if (bus_reqack && cnt_q == 3'd7) state_d = IDLE;
            LATENCY: if (lat_q == 4'd0)               state_d = RESP;
            RESP:    if (resp_hs && cnt_q == 3'd7)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        unique case (state_q)
            IDLE, WDATA: bus_reqack  = bus_reqcyc & ~reset;
            RESP:        bus_respcyc = 1'b1;
            default: ;
        endcase
    end

    // Word to load into bus_resp when the next beat is presented.
    always_comb begin
        rd_line = line_q;
        rd_beat = 3'd0;
        if (state_q == IDLE)      rd_line = req_line;
        else if (state_q == RESP) rd_beat = cnt_q + 3'd1;
        rd_word = mem[{rd_line, rd_beat}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
            cnt_q  <= '0;
            lat_q  <= '0;
            tag_q  <= '0;
            resp_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus_reqack && is_mem) begin
                        line_q <= req_line;
                        cnt_q  <= 3'd0;
                        lat_q  <= LAT_INIT;
                        if (is_rd) begin
                            tag_q <= bus_reqtag;
                            if (RESP_LATENCY == 0) resp_q <= rd_word;
                        end
                    end
                end
                WDATA: if (bus_reqack) cnt_q <= cnt_q + 3'd1;
                LATENCY: begin
                    if (lat_q == 4'd0) resp_q <= rd_word;
                    else               lat_q  <= lat_q - 4'd1;
                end
                RESP: begin
                    if (resp_hs && cnt_q != 3'd7) begin
                        resp_q <= rd_word;
                        cnt_q  <= cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus write is the later assignment, so it wins a same-word collision with preload.
    always_ff @(posedge clk) begin
        if (preload_we) mem[preload_addr] <= preload_data;
        if (wr_en)      mem[{line_q, cnt_q}] <= bus_req;
    end

endmodule
